// File: rtl/breathing_led_array.sv
// breathing_led_array: multi-channel breathing-LED PWM generator with per-channel phase offset
module breathing_led_array #(
  parameter int N_CH      = 4,
  parameter int DUTY_W    = 8,
  parameter int TICK_DIV  = 105488,
  parameter int PHASE_OFS = 64
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [DUTY_W-1:0] static_duty,
  output logic [N_CH-1:0]   breath_out,
  output logic              cycle_pulse,
  output logic [DUTY_W-1:0] level0
);
  localparam int M  = 2 ** DUTY_W;
  localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [DUTY_W-1:0] pwm_cnt;
  logic [TW-1:0]     tick;
  logic [DUTY_W:0]   pos;
  logic              run;
  logic              step;
  logic [DUTY_W-1:0] level [N_CH];
  logic [N_CH-1:0]   cmp;
  assign run  = en && !mode[1];
  assign step = run && tick == TW'(TICK_DIV - 1);
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    localparam logic [DUTY_W:0] OFS = (DUTY_W + 1)'((i * PHASE_OFS) % (2 * M));
    logic [DUTY_W:0] p;
    assign p        = pos + OFS;
    // triangle folds the upper half of the phase back down: 0..M-1, M-1..0
    assign level[i] = mode == 2'd0 ? (p[DUTY_W] ? ~p[DUTY_W-1:0] : p[DUTY_W-1:0]) :
                      mode == 2'd1 ? p[DUTY_W-1:0] :
                      mode == 2'd2 ? static_duty : '0;
    assign cmp[i]   = en && pwm_cnt < level[i];
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      pwm_cnt     <= '0;
      tick        <= '0;
      pos         <= '0;
      cycle_pulse <= 1'b0;
      breath_out  <= '0;
      level0      <= '0;
    end else begin
      pwm_cnt     <= pwm_cnt + 1'b1;
      tick        <= (mode == 2'd3 || step) ? '0 : run ? tick + 1'b1 : tick;
      pos         <= mode == 2'd3 ? '0 : step ? pos + 1'b1 : pos;
      cycle_pulse <= step && &pos;
      breath_out  <= cmp;
      level0      <= en ? level[0] : '0;
    end
endmodule

// File: tb/tb_breathing_led_array.sv
// tb_breathing_led_array: scoreboard bench for breathing_led_array (N_CH=2, DUTY_W=3, TICK_DIV=4)
module tb_breathing_led_array;
  localparam int N_CH = 2, DUTY_W = 3, TICK_DIV = 4, PHASE_OFS = 4;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic en = 1'b1;
  logic [1:0] mode = 2'd0;
  logic [2:0] static_duty = 3'd0;
  logic [1:0] breath_out;
  logic cycle_pulse;
  logic [2:0] level0;
  breathing_led_array #(.N_CH(N_CH), .DUTY_W(DUTY_W), .TICK_DIV(TICK_DIV), .PHASE_OFS(PHASE_OFS)) dut (
    .clk(clk), .rstn(rstn), .en(en), .mode(mode), .static_duty(static_duty),
    .breath_out(breath_out), .cycle_pulse(cycle_pulse), .level0(level0)
  );
  always #5 clk = ~clk;
  typedef struct packed {logic [1:0] bo; logic cp; logic [2:0] l0;} exp_t;
  exp_t sb[$];
  int pulses[$];
  int tri_tab [16] = '{0, 1, 2, 3, 4, 5, 6, 7, 7, 6, 5, 4, 3, 2, 1, 0};
  int n_tests = 0, n_fail = 0;
  int m_pwm, m_tick, m_pos, cyc;
  int hi0, hi1, guard;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask
  function automatic int lvl(int i);
    int p;
    p = (m_pos + i * PHASE_OFS) % 16;
    return mode == 2'd0 ? tri_tab[p] : mode == 2'd1 ? p % 8 : mode == 2'd2 ? int'(static_duty) : 0;
  endfunction
  task automatic model_reset();
    m_pwm = 0; m_tick = 0; m_pos = 0;
  endtask
  // push expectation from the reference model, clock once, pop and compare
  task automatic cycle_step(string tag);
    exp_t e;
    bit run, stp;
    run  = en && mode < 2;
    stp  = run && m_tick == TICK_DIV - 1;
    e.bo = {en && m_pwm < lvl(1), en && m_pwm < lvl(0)};
    e.cp = stp && m_pos == 15;
    e.l0 = en ? 3'(lvl(0)) : 3'd0;
    sb.push_back(e);
    m_pwm = (m_pwm + 1) % 8;
    if (mode == 2'd3) begin m_tick = 0; m_pos = 0; end
    else if (stp) begin m_tick = 0; m_pos = (m_pos + 1) % 16; end
    else if (run) m_tick++;
    @(posedge clk); #1; cyc++;
    e = sb.pop_front();
    chk({tag, ".breath_out"}, breath_out, e.bo);
    chk({tag, ".cycle_pulse"}, cycle_pulse, e.cp);
    chk({tag, ".level0"}, level0, e.l0);
    if (cycle_pulse) pulses.push_back(cyc);
  endtask
  task automatic chk_gaps(string tag);
    chk({tag, ".pulse_count"}, pulses.size() >= 2, 1);
    for (int k = 1; k < pulses.size(); k++) chk({tag, ".pulse_gap"}, pulses[k] - pulses[k-1], 64);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    cyc = 0;
    repeat (5) begin
      @(posedge clk); #1;
      chk("reset.breath_out", breath_out, 0);
      chk("reset.cycle_pulse", cycle_pulse, 0);
      chk("reset.level0", level0, 0);
    end
    rstn = 1'b1;
    model_reset();
    pulses.delete();
    repeat (140) cycle_step("tri");
    chk_gaps("tri");
    mode = 2'd1;
    pulses.delete();
    repeat (140) cycle_step("saw");
    chk_gaps("saw");
    mode = 2'd0;
    repeat (13) cycle_step("tri2");
    mode = 2'd2; static_duty = 3'd5; hi0 = 0; hi1 = 0;
    repeat (96) begin
      cycle_step("static5");
      hi0 += breath_out[0]; hi1 += breath_out[1];
    end
    chk("static5.ch0_high", hi0, 60);
    chk("static5.ch1_high", hi1, 60);
    repeat (4) cycle_step("static5");
    mode = 2'd0;
    repeat (20) cycle_step("resume");
    mode = 2'd2; static_duty = 3'd0; hi0 = 0; hi1 = 0;
    repeat (16) begin
      cycle_step("static0");
      hi0 += breath_out[0]; hi1 += breath_out[1];
    end
    chk("static0.ch0_high", hi0, 0);
    chk("static0.ch1_high", hi1, 0);
    mode = 2'd0;
    repeat (10) cycle_step("pre_en");
    en = 1'b0;
    repeat (12) cycle_step("en0");
    chk("en0.breath_out", breath_out, 0);
    en = 1'b1;
    repeat (20) cycle_step("en1");
    guard = 0;
    while (!(m_pos == 15 && m_tick == TICK_DIV - 1) && guard < 100) begin
      cycle_step("seek");
      guard++;
    end
    chk("seek.reached", guard < 100, 1);
    mode = 2'd3;
    cycle_step("off_step");
    chk("off_step.no_pulse", cycle_pulse, 0);
    repeat (5) cycle_step("off");
    mode = 2'd0;
    repeat (40) cycle_step("leave_off");
    mode = 2'd2; static_duty = 3'd7;
    repeat (9) cycle_step("pre_rst");
    #3 rstn = 1'b0;
    #1;
    chk("async_rst.breath_out", breath_out, 0);
    chk("async_rst.cycle_pulse", cycle_pulse, 0);
    chk("async_rst.level0", level0, 0);
    @(posedge clk); #1;
    chk("rst_hold.level0", level0, 0);
    rstn = 1'b1;
    model_reset();
    mode = 2'd0;
    repeat (40) cycle_step("post_rst");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
